// File: rtl/cmos_rgb565_capture_if.sv
// DVP camera byte bus plus framed RGB565 pixel stream.
// master drives the camera side; slave is the capture block.
interface cmos_rgb565_capture_if;
  logic        cmos_vsync;
  logic        cmos_href;
  logic [7:0]  cmos_data;
  logic [15:0] dout;
  logic        dout_vld;
  logic        dout_sop;
  logic        dout_eop;
  logic        frame_err;

  modport master (
    output cmos_vsync,
    output cmos_href,
    output cmos_data,
    input  dout,
    input  dout_vld,
    input  dout_sop,
    input  dout_eop,
    input  frame_err
  );

  modport slave (
    input  cmos_vsync,
    input  cmos_href,
    input  cmos_data,
    output dout,
    output dout_vld,
    output dout_sop,
    output dout_eop,
    output frame_err
  );
endinterface

// File: rtl/cmos_rgb565_capture.sv
// DVP byte stream to sop/eop-framed RGB565 pixels.
// Define CAPTURE_FRAME_SKIP_EN to drop SKIP_FRAMES start-up frames.
module cmos_rgb565_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SKIP_FRAMES = 10
) (
  input logic                  clk,
  input logic                  rst_n,
  cmos_rgb565_capture_if.slave bus
);

  typedef enum logic [1:0] {
    S_SKIP,
    S_WAIT,
    S_ACTIVE
  } state_t;

  localparam logic [11:0] LP_H   = 12'(H_ACTIVE);
  localparam logic [11:0] LP_HM1 = 12'(H_ACTIVE - 1);
  localparam logic [11:0] LP_V   = 12'(V_ACTIVE);
  localparam logic [11:0] LP_VM1 = 12'(V_ACTIVE - 1);

`ifdef CAPTURE_FRAME_SKIP_EN
  localparam logic [7:0] LP_SKIP = 8'(SKIP_FRAMES);
  localparam state_t LP_RST_ST =
    (SKIP_FRAMES == 0) ? S_WAIT : S_SKIP;
`else
  localparam state_t LP_RST_ST = S_WAIT;
`endif

  if (H_ACTIVE < 2 || H_ACTIVE > 4095 ||
      V_ACTIVE < 1 || V_ACTIVE > 4095 ||
      SKIP_FRAMES < 0 || SKIP_FRAMES > 255) begin : g_bad_param
    $error("cmos_rgb565_capture: parameter out of range");
  end

  logic        r_vs, r_vs_d;
  logic        r_hs, r_hs_d;
  logic [7:0]  r_d;
  state_t      r_state;
  logic [11:0] r_x, r_y;
  logic        r_ph;
  logic [7:0]  r_hi;
  logic [15:0] r_dout;
  logic        r_vld, r_sop, r_eop, r_err;

  logic        w_vs_fall, w_vs_rise, w_hs_fall;
  state_t      w_state_nxt;
  logic [11:0] w_x_nxt, w_y_nxt;
  logic        w_ph_nxt;
  logic [7:0]  w_hi_nxt;
  logic [15:0] w_pix;
  logic        w_vld, w_sop, w_eop, w_err;

`ifdef CAPTURE_FRAME_SKIP_EN
  logic [7:0]  r_skip;
  logic [7:0]  w_skip_nxt;
`endif

  assign w_vs_fall = r_vs_d & ~r_vs;
  assign w_vs_rise = ~r_vs_d & r_vs;
  assign w_hs_fall = r_hs_d & ~r_hs;
  assign w_pix     = {r_hi, r_d};

  // Register camera inputs and keep one-cycle history for edges
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_vs   <= 1'b0;
      r_vs_d <= 1'b0;
      r_hs   <= 1'b0;
      r_hs_d <= 1'b0;
      r_d    <= 8'd0;
    end else begin
      r_vs   <= bus.cmos_vsync;
      r_vs_d <= r_vs;
      r_hs   <= bus.cmos_href;
      r_hs_d <= r_hs;
      r_d    <= bus.cmos_data;
    end
  end

  // Next state, byte pairing, x/y counting and output flags
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_ph_nxt    = r_ph;
    w_hi_nxt    = r_hi;
    w_vld       = 1'b0;
    w_sop       = 1'b0;
    w_eop       = 1'b0;
    w_err       = 1'b0;
`ifdef CAPTURE_FRAME_SKIP_EN
    w_skip_nxt  = r_skip;
`endif
    unique case (r_state)
      S_SKIP: begin
`ifdef CAPTURE_FRAME_SKIP_EN
        if (w_vs_fall) begin
          w_skip_nxt = r_skip + 8'd1;
          if (r_skip + 8'd1 == LP_SKIP)
            w_state_nxt = S_WAIT;
        end
`else
        w_state_nxt = S_WAIT;
`endif
      end
      S_WAIT: begin
        if (w_vs_fall) begin
          w_state_nxt = S_ACTIVE;
          w_x_nxt     = 12'd0;
          w_y_nxt     = 12'd0;
          w_ph_nxt    = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (r_hs) begin
          w_ph_nxt = ~r_ph;
          if (!r_ph) begin
            w_hi_nxt = r_d;
          end else begin
            // saturate so a runaway line can never wrap to x<H
            if (r_x != 12'hFFF)
              w_x_nxt = r_x + 12'd1;
            if (r_x < LP_H && r_y < LP_V) begin
              w_vld = 1'b1;
              w_sop = (r_x == 12'd0) && (r_y == 12'd0);
              w_eop = (r_x == LP_HM1) && (r_y == LP_VM1);
            end
          end
        end else begin
          w_ph_nxt = 1'b0;
          if (w_hs_fall && r_x != 12'd0) begin
            w_x_nxt = 12'd0;
            if (r_y != 12'hFFF)
              w_y_nxt = r_y + 12'd1;
          end
        end
        // eop beats a coincident vsync rise
        if (w_eop) begin
          w_state_nxt = S_WAIT;
        end else if (w_vs_rise) begin
          w_err       = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      default: w_state_nxt = LP_RST_ST;
    endcase
  end

  // State, counters and pairing register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= LP_RST_ST;
      r_x     <= 12'd0;
      r_y     <= 12'd0;
      r_ph    <= 1'b0;
      r_hi    <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_ph    <= w_ph_nxt;
      r_hi    <= w_hi_nxt;
    end
  end

`ifdef CAPTURE_FRAME_SKIP_EN
  // Count discarded start-up frames
  always_ff @(posedge clk) begin
    if (rst_n)
      r_skip <= 8'd0;
    else
      r_skip <= w_skip_nxt;
  end
`endif

  // Output register; pixel data holds between pulses
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_dout <= 16'd0;
      r_vld  <= 1'b0;
      r_sop  <= 1'b0;
      r_eop  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_vld)
        r_dout <= w_pix;
      r_vld <= w_vld;
      r_sop <= w_sop;
      r_eop <= w_eop;
      r_err <= w_err;
    end
  end

  assign bus.dout      = r_dout;
  assign bus.dout_vld  = r_vld;
  assign bus.dout_sop  = r_sop;
  assign bus.dout_eop  = r_eop;
  assign bus.frame_err = r_err;

endmodule

// File: tb/tb_cmos_rgb565_capture.sv
// Randomized frame stimulus for cmos_rgb565_capture.
// A frame-level model predicts every pixel and frame_err pulse.
module tb_cmos_rgb565_capture;
  localparam int H = 4;
  localparam int V = 2;
`ifdef CAPTURE_FRAME_SKIP_EN
  localparam int SKIP_PAR = 2;
`else
  localparam int SKIP_PAR = 0;
`endif

  typedef struct {
    logic [15:0] d;
    bit          sop;
    bit          eop;
    int          cyc;
  } px_t;

  typedef struct {
    logic [15:0] d;
    bit          sop;
    bit          eop;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   nvec = 0;
  int   nbad = 0;
  int   skip_left = 0;
  int   errs_seen = 0;
  px_t  q[$];
  int   eq[$];
  obs_t obs[$];

  cmos_rgb565_capture_if bus();

  cmos_rgb565_capture #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .SKIP_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic chk_zero_outs(input string nm);
    chk({nm, "_dout"}, 32'(bus.dout), 0);
    chk({nm, "_vld"}, 32'(bus.dout_vld), 0);
    chk({nm, "_sop"}, 32'(bus.dout_sop), 0);
    chk({nm, "_eop"}, 32'(bus.dout_eop), 0);
    chk({nm, "_err"}, 32'(bus.frame_err), 0);
  endtask

  // one clock step; a one-cycle reset pulse is released here
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) begin
      chk_zero_outs("midrst");
      rst_n = 1'b0;
    end
  endtask

  // reset asserted at launch cycle k: nothing due after edge k survives
  task automatic model_reset(input int k);
    px_t t[$];
    int  te[$];
    foreach (q[i]) if (q[i].cyc <= k) t.push_back(q[i]);
    foreach (eq[i]) if (eq[i] <= k) te.push_back(eq[i]);
    q  = t;
    eq = te;
    skip_left = SKIP_PAR;
  endtask

  task automatic send_frame(input int lens[$], input bit fixed,
                            input bit rwl, input int rl,
                            input int rb);
    logic [7:0] b, hi, seq;
    bit cap, eopd;
    int y, p, nl;
    seq = 8'h12;
    hi  = 8'h00;
    nl  = lens.size();
    tick();
    bus.cmos_vsync = 1'b0;
    if (skip_left > 0) begin
      skip_left--;
      cap = 1'b0;
    end else begin
      cap = 1'b1;
    end
    y = 0;
    eopd = 1'b0;
    tick();
    tick();
    for (int l = 0; l < nl; l++) begin
      for (int j = 0; j < lens[l]; j++) begin
        tick();
        b = fixed ? seq : 8'($urandom);
        seq = seq + 8'h22;
        bus.cmos_href = 1'b1;
        bus.cmos_data = b;
        if (j % 2 == 0) begin
          hi = b;
        end else begin
          p = j / 2;
          if (cap && !eopd && p < H && y < V) begin
            q.push_back('{{hi, b}, (p == 0 && y == 0),
                          (p == H - 1 && y == V - 1), cyc + 2});
            if (p == H - 1 && y == V - 1) eopd = 1'b1;
          end
        end
        if (rwl && l == nl - 1 && j == lens[l] - 1) begin
          bus.cmos_vsync = 1'b1;
          if (cap && !eopd) eq.push_back(cyc + 2);
        end
        if (l == rl && j == rb) begin
          rst_n = 1'b1;
          model_reset(cyc);
          cap = 1'b0;
        end
      end
      if (lens[l] >= 2) y++;
      repeat (1 + $urandom_range(0, 2)) begin
        tick();
        bus.cmos_href = 1'b0;
      end
    end
    if (!rwl) begin
      tick();
      bus.cmos_vsync = 1'b1;
      if (cap && !eopd) eq.push_back(cyc + 2);
    end
    repeat (4) tick();
  endtask

  task automatic rand_frame();
    int L[$];
    int n;
    bit rwl;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) L.push_back($urandom_range(0, 13));
    rwl = ($urandom_range(0, 3) == 0) && (L[n-1] > 0);
    send_frame(L, 1'b0, rwl, -1, -1);
  endtask

  // compare DUT outputs with the model on every cycle
  logic        prev_vld = 1'b0;
  logic        prev_rst = 1'b1;
  logic [15:0] last_dout = 16'd0;
  always @(negedge clk) begin
    px_t e;
    if (bus.dout_vld === 1'b1) begin
      obs.push_back('{bus.dout, bus.dout_sop, bus.dout_eop});
      chk("vld_back_to_back", 32'(prev_vld), 0);
      if (q.size() == 0) begin
        nvec++;
        nbad++;
        $display("FAIL unexpected_vld: dout=%h cycle %0d, none required",
                 bus.dout, cyc);
      end else begin
        e = q.pop_front();
        chk("dout", 32'(bus.dout), 32'(e.d));
        chk("sop", 32'(bus.dout_sop), 32'(e.sop));
        chk("eop", 32'(bus.dout_eop), 32'(e.eop));
        chk("latency_cycle", cyc, e.cyc);
      end
    end else begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        nvec++;
        nbad++;
        $display("FAIL missing_vld: no pulse, required dout=%h at cycle %0d",
                 e.d, e.cyc);
      end
      chk("idle_flags", {30'd0, bus.dout_sop, bus.dout_eop}, 0);
      if (!prev_rst) chk("dout_hold", 32'(bus.dout), 32'(last_dout));
    end
    if (bus.frame_err === 1'b1) begin
      errs_seen++;
      if (eq.size() > 0 && eq[0] == cyc) begin
        void'(eq.pop_front());
        nvec++;
      end else begin
        nvec++;
        nbad++;
        $display("FAIL unexpected_frame_err: got 1 at cycle %0d, required 0",
                 cyc);
      end
    end else if (eq.size() > 0 && eq[0] < cyc) begin
      nvec++;
      nbad++;
      $display("FAIL missing_frame_err: got 0, required 1 at cycle %0d",
               eq.pop_front());
    end
    prev_vld  = bus.dout_vld;
    prev_rst  = rst_n;
    last_dout = bus.dout;
  end

  initial begin
    int L[$];
    int e0;
    bus.cmos_vsync = 1'b1;
    bus.cmos_href  = 1'b0;
    bus.cmos_data  = 8'd0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outs("reset");
    rst_n = 1'b0;
    skip_left = SKIP_PAR;
    repeat (SKIP_PAR) rand_frame();

    // clean frame, fixed byte ramp 0x12,0x34,...
    obs.delete();
    e0 = errs_seen;
    L = {8, 8};
    send_frame(L, 1'b1, 1'b0, -1, -1);
    chk("clean_count", obs.size(), 8);
    if (obs.size() >= 8) begin
      chk("clean_first", 32'(obs[0].d), 32'h1234);
      chk("clean_first_sop", 32'(obs[0].sop), 1);
      chk("clean_last", 32'(obs[7].d), 32'hEE10);
      chk("clean_last_eop", 32'(obs[7].eop), 1);
    end
    chk("clean_no_err", errs_seen - e0, 0);

    // odd 9-byte line: trailing byte dropped, next line restarts
    obs.delete();
    L = {9, 8};
    send_frame(L, 1'b1, 1'b0, -1, -1);
    chk("odd_count", obs.size(), 8);
    if (obs.size() >= 8) begin
      chk("odd_line2_first", 32'(obs[4].d), 32'h4466);
      chk("odd_eop", 32'(obs[7].eop), 1);
    end

    // vsync rises after line 1 of 2
    obs.delete();
    e0 = errs_seen;
    L = {8};
    send_frame(L, 1'b1, 1'b0, -1, -1);
    chk("abort_err", errs_seen - e0, 1);
    chk("abort_count", obs.size(), 4);
    if (obs.size() >= 4) chk("abort_no_eop", 32'(obs[3].eop), 0);

    obs.delete();
    L = {8, 8};
    send_frame(L, 1'b1, 1'b0, -1, -1);
    chk("after_abort_count", obs.size(), 8);
    if (obs.size() >= 1) chk("after_abort_sop", 32'(obs[0].sop), 1);

    // 6-pixel line at H=4
    obs.delete();
    L = {12, 8};
    send_frame(L, 1'b1, 1'b0, -1, -1);
    chk("long_count", obs.size(), 8);
    if (obs.size() >= 8)
      chk("long_line2_first", 32'(obs[4].d), 32'hAACC);

    // vsync rises on the eop pixel itself
    obs.delete();
    e0 = errs_seen;
    L = {8, 8};
    send_frame(L, 1'b1, 1'b1, -1, -1);
    chk("eop_vs_err", errs_seen - e0, 0);
    if (obs.size() >= 8) chk("eop_vs_eop", 32'(obs[7].eop), 1);

    // one-cycle reset mid-line
    obs.delete();
    e0 = errs_seen;
    L = {8, 8};
    send_frame(L, 1'b1, 1'b0, 0, 5);
    chk("midrst_count", obs.size(), 2);
    chk("midrst_no_err", errs_seen - e0, 0);
    repeat (SKIP_PAR) rand_frame();
    obs.delete();
    L = {8, 8};
    send_frame(L, 1'b1, 1'b0, -1, -1);
    chk("post_rst_count", obs.size(), 8);
    if (obs.size() >= 1) chk("post_rst_sop", 32'(obs[0].sop), 1);

    repeat (60) rand_frame();

    repeat (8) tick();
    chk("pending_pixels", q.size(), 0);
    chk("pending_errs", eq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/cmos_rgb565_capture.md
# cmos_rgb565_capture

Front-end capture stage that converts an 8-bit DVP camera byte stream (vsync/href/data) into framed RGB565 pixels with valid/start-of-packet/end-of-packet flags. It sits directly upstream of the RGB565-to-grayscale stage and drives that stage's `din`/`din_vld`/`din_sop`/`din_eop` inputs. It pairs bytes into pixels, counts columns and lines, and emits one sop/eop-framed packet per camera frame. It optionally discards start-up frames while the sensor settles.

## Interface
- `H_ACTIVE`, 640: pixels per line; range 2..4095.
- `V_ACTIVE`, 480: lines per frame; range 1..4095.
- `SKIP_FRAMES`, 10: complete frames discarded after reset; range 0..255. Used only with `CAPTURE_FRAME_SKIP_EN`.
- `clk`  in  1  pixel clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-high reset; the name follows codebase convention, but asserting it high resets the block.
- `cmos_vsync`  in  1  frame sync; high = vertical blanking.
- `cmos_href`  in  1  line valid; high = active bytes on `cmos_data`.
- `cmos_data`  in  8  camera byte; first byte of pair = RGB565[15:8], second = [7:0].
- `dout`  out  16  RGB565 pixel.
- `dout_vld`  out  1  `dout` valid, one-cycle pulse per pixel.
- `dout_sop`  out  1  high with `dout_vld` on pixel (0,0) of a frame.
- `dout_eop`  out  1  high with `dout_vld` on pixel (`H_ACTIVE`-1, `V_ACTIVE`-1).
- `frame_err`  out  1  one-cycle pulse when a frame is aborted.

## Operation
- Input registering
  - All inputs are registered once before use.
  - `vs_fall` = registered vsync 1→0; `vs_rise` = registered vsync 0→1.
- FSM states and transitions
  - SKIP: count `vs_fall` events until the count reaches `SKIP_FRAMES`, then go to WAIT.
  - WAIT: on `vs_fall`, go to ACTIVE and clear `x`, `y`, and the byte phase.
  - ACTIVE: capture bytes. On the eop pixel, go to WAIT. On `vs_rise` before eop, pulse `frame_err`, go to WAIT, and emit no eop.
- Byte pairing
  - In ACTIVE, while registered href=1, the byte phase toggles every cycle.
  - Phase 0 latches the high byte. Phase 1 forms a pixel `{hi, data}`.
  - When href=0, the phase clears, so a trailing odd byte is dropped.
- Counters
  - `x` increments per formed pixel.
  - On the href 1→0 edge, if `x`≠0: clear `x` and increment `y`.
  - Pixels with `x`≥`H_ACTIVE` or `y`≥`V_ACTIVE` are discarded (no `dout_vld`).
  - A short line (fewer than `H_ACTIVE` pixels) still advances `y`, and its pixels are emitted.
- Output flags
  - `dout_sop` = vld & `x`==0 & `y`==0.
  - `dout_eop` = vld & `x`==`H_ACTIVE`-1 & `y`==`V_ACTIVE`-1.
- Unreachable eop: if href lines end before `V_ACTIVE` lines are seen, no eop is produced and the next `vs_rise` raises `frame_err`.
- Reset
  - Takes effect on any cycle, mid-frame included.
  - FSM goes to SKIP (or WAIT without the macro); counters clear; all outputs go to 0.
  - A partial frame is never resumed.

## Timing
- Reset values: `dout`=0, `dout_vld`=0, `dout_sop`=0, `dout_eop`=0, `frame_err`=0.
- Latency: with the second byte of a pair on `cmos_data` at edge N, `dout`/`dout_vld` are high after edge N+2 (input reg + output reg).
- Throughput: max one pixel every 2 cycles. `dout_vld` is never high on two consecutive cycles.
- `dout` holds its last value when `dout_vld`=0.
- `frame_err` is registered with the same 2-cycle latency from the `cmos_vsync` edge.
- No backpressure: downstream must accept every `dout_vld`.
- Simultaneous eop pixel and `vs_rise` in the same cycle: eop wins, and no `frame_err` is raised.

## Configuration
- `CAPTURE_FRAME_SKIP_EN` defined:
  - SKIP state and the 8-bit frame counter are built.
  - The first `SKIP_FRAMES` vsync-falling edges after reset produce no output.
  - `SKIP_FRAMES`=0 goes straight to WAIT.
- Not defined:
  - SKIP state and counter are removed.
  - Reset enters WAIT; the first `vs_fall` after reset starts a captured frame.

## Test plan
- H=4, V=2, macro off, one clean frame with bytes 0x12,0x34,0x56,0x78,…
  - Expect 8 `dout_vld` pulses, first `dout`=0x1234 with sop=1.
  - Last pulse has eop=1; each pulse 2 cycles after its low byte.
  - `frame_err` stays 0.
- Macro on, `SKIP_FRAMES`=2, four frames: only frames 3 and 4 are output, each with exactly one sop and one eop.
- Line with 9 bytes at H=4: 4 pixels emitted; the 9th byte dropped; the next line starts with `x`=0.
- `vsync` rises after line 1 of 2: `frame_err`=1 for one cycle, no eop; the next frame is captured normally with sop.
- Line with 6 pixels at H=4: only pixels 0–3 are valid; pixels 4–5 produce no `dout_vld`.
- `rst_n` high for 1 cycle mid-line: all outputs 0 the next cycle; no output until after the next `vsync` fall (plus skip frames if the macro is on).
